// File: rtl/significand_divider_if.sv
// Handshake and operand/result bundle for significand_divider.
// master: requester driving operands and start; slave: the divider.
interface significand_divider_if #(
    parameter int unsigned BIT_WIDTH = 10
);
    logic                 i_start;
    logic [BIT_WIDTH-1:0] i_input_a;
    logic [BIT_WIDTH-1:0] i_input_b;
    logic                 i_hidden_bit_a;
    logic                 i_hidden_bit_b;
    logic [BIT_WIDTH-1:0] o_result;
    logic                 o_valid;
    logic                 o_busy;
    logic                 o_significand_msb;
    logic                 o_div_by_zero;

    modport master (
        output i_start, i_input_a, i_input_b, i_hidden_bit_a, i_hidden_bit_b,
        input  o_result, o_valid, o_busy, o_significand_msb, o_div_by_zero
    );

    modport slave (
        input  i_start, i_input_a, i_input_b, i_hidden_bit_a, i_hidden_bit_b,
        output o_result, o_valid, o_busy, o_significand_msb, o_div_by_zero
    );
endinterface

// File: rtl/significand_divider.sv
// Restoring shift-and-subtract divider for half-precision significands.
// Computes 1.a / 1.b to BIT_WIDTH+4 quotient bits, normalises by at most one
// place and reports whether the quotient was >= 1.0 (significand_msb).
// Optional feature macro: SIGNIFICAND_DIV_ROUND_EN selects round-to-nearest-even;
// without it the normalised fraction is truncated.
// Outputs are registered from the next-cycle values of Q, R and dbz, so they
// track those registers exactly and hold from VALID until the next load.
module significand_divider #(
    parameter int unsigned BIT_WIDTH = 10
) (
    input  logic clk,
    input  logic reset_b,
    significand_divider_if.slave bus
);

    localparam int unsigned SIG_W = BIT_WIDTH + 1;
    localparam int unsigned REM_W = BIT_WIDTH + 2;
    localparam int unsigned QUO_W = BIT_WIDTH + 4;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_WIDTH + 3);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_VALID  = 2'd2
    } state_t;

    state_t               r_state;
    logic [REM_W-1:0]     r_rem;
    logic [SIG_W-1:0]     r_div;
    logic [QUO_W-1:0]     r_quo;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_dbz;
    logic [BIT_WIDTH-1:0] r_result;
    logic                 r_msb;
    logic                 r_valid;
    logic                 r_busy;

    state_t               w_state_next;
    logic [REM_W-1:0]     w_rem_next;
    logic [SIG_W-1:0]     w_div_next;
    logic [QUO_W-1:0]     w_quo_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_dbz_next;
    logic                 w_ge;
    logic [REM_W-1:0]     w_diff;
    logic [SIG_W-1:0]     w_load_div;
    logic                 w_norm_msb;
    logic [BIT_WIDTH-1:0] w_frac;
    logic [BIT_WIDTH-1:0] w_result_next;
    logic                 w_msb_next;
`ifdef SIGNIFICAND_DIV_ROUND_EN
    logic                 w_guard;
    logic                 w_round_bit;
    logic                 w_sticky;
`endif

    // Trial subtraction of the divisor from the partial remainder.
    assign w_ge       = (r_rem >= REM_W'(r_div));
    assign w_diff     = r_rem - REM_W'(r_div);
    assign w_load_div = {bus.i_hidden_bit_b, bus.i_input_b};

    // Next-state and datapath update: load in IDLE, one quotient bit per DIVIDE cycle.
    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        w_div_next   = r_div;
        w_quo_next   = r_quo;
        w_cnt_next   = r_cnt;
        w_dbz_next   = r_dbz;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_state_next = S_DIVIDE;
                    w_rem_next   = {1'b0, bus.i_hidden_bit_a, bus.i_input_a};
                    w_div_next   = w_load_div;
                    w_quo_next   = '0;
                    w_cnt_next   = '0;
                    w_dbz_next   = (w_load_div == '0);
                end
            end
            S_DIVIDE: begin
                if (w_ge) begin
                    w_rem_next = {w_diff[REM_W-2:0], 1'b0};
                end else begin
                    w_rem_next = {r_rem[REM_W-2:0], 1'b0};
                end
                w_quo_next = {r_quo[QUO_W-2:0], w_ge};
                w_cnt_next = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_CNT) begin
                    w_state_next = S_VALID;
                end
            end
            S_VALID: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Normalise the next quotient by one place when it is below 1.0, then round or truncate.
    always_comb begin
        w_norm_msb = w_quo_next[QUO_W-1];
        if (w_norm_msb) begin
            w_frac = w_quo_next[QUO_W-2:3];
        end else begin
            w_frac = w_quo_next[QUO_W-3:2];
        end
`ifdef SIGNIFICAND_DIV_ROUND_EN
        if (w_norm_msb) begin
            w_guard     = w_quo_next[2];
            w_round_bit = w_quo_next[1];
            w_sticky    = w_quo_next[0] | (w_rem_next != '0);
        end else begin
            w_guard     = w_quo_next[1];
            w_round_bit = w_quo_next[0];
            w_sticky    = (w_rem_next != '0);
        end
        if (w_guard & (w_round_bit | w_sticky | w_frac[0])) begin
            w_result_next = w_frac + BIT_WIDTH'(1);
        end else begin
            w_result_next = w_frac;
        end
`else
        w_result_next = w_frac;
`endif
        w_msb_next = w_norm_msb;
        if (w_dbz_next) begin
            w_result_next = '0;
            w_msb_next    = 1'b0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_div    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_dbz    <= 1'b0;
            r_result <= '0;
            r_msb    <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rem    <= w_rem_next;
            r_div    <= w_div_next;
            r_quo    <= w_quo_next;
            r_cnt    <= w_cnt_next;
            r_dbz    <= w_dbz_next;
            r_result <= w_result_next;
            r_msb    <= w_msb_next;
            r_valid  <= (w_state_next == S_VALID);
            r_busy   <= (w_state_next != S_IDLE);
        end
    end

    assign bus.o_result          = r_result;
    assign bus.o_valid           = r_valid;
    assign bus.o_busy            = r_busy;
    assign bus.o_significand_msb = r_msb;
    assign bus.o_div_by_zero     = r_dbz;

endmodule
